// File: rtl/cfg_counter_pkg.sv
// Shared types for the configurable counter: counting modes and FSM states.
package cfg_counter_pkg;

  // Counting behaviour at the terminal count; MODE_RSVD decodes as MODE_WRAP.
  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_e;

  // RUN counts normally; DONE is the parked state after a one-shot completes.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_e;

  // True when the mode should behave as a wrapping counter.
  function automatic logic is_wrap_mode(mode_e m);
    return (m == MODE_WRAP) || (m == MODE_RSVD);
  endfunction

endpackage

// File: rtl/cfg_counter_prescaler.sv
// Prescaler: emits one tick every presc_i+1 cycles in which run_i is high.
// Counting holds while run_i is low; restart_i returns the phase to zero.
module cfg_counter_prescaler #(
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  restart_i,
  input  logic                  run_i,
  input  logic [PRESCALE_W-1:0] presc_i,
  output logic                  tick_o
);

  logic [PRESCALE_W-1:0] psc_q;
  logic [PRESCALE_W-1:0] psc_d;
  logic                  hit;

  // A tick fires on the enabled cycle where the phase equals the divisor.
  // If presc_i drops below the phase the counter wraps through 2^PRESCALE_W.
  assign hit    = (psc_q == presc_i);
  assign tick_o = run_i & hit;

  // Next phase: restart wins, then advance only while running.
  always_comb begin
    psc_d = psc_q;
    if (restart_i) begin
      psc_d = '0;
    end else if (run_i) begin
      if (hit) begin
        psc_d = '0;
      end else begin
        psc_d = psc_q + 1'b1;
      end
    end
  end

  // Phase register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      psc_q <= '0;
    end else begin
      psc_q <= psc_d;
    end
  end

endmodule

// File: rtl/cfg_counter.sv
// Runtime-configurable up/down counter with terminal count, parallel load,
// prescaler, wrap/saturate/one-shot modes and a combinational compare match.
// Per-cycle priority: reset, then clear, then load, then a prescaled tick.
module cfg_counter
  import cfg_counter_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  clear_i,
  input  logic                  load_i,
  input  logic [WIDTH-1:0]      load_val_i,
  input  logic                  dir_i,
  input  logic [1:0]            mode_i,
  input  logic [WIDTH-1:0]      max_i,
  input  logic [PRESCALE_W-1:0] presc_i,
  input  logic [WIDTH-1:0]      cmp_i,
  output logic [WIDTH-1:0]      count_o,
  output logic                  ovf_o,
  output logic                  unf_o,
  output logic                  done_o,
  output logic                  match_o
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  state_e           state_q, state_d;

  mode_e            mode;
  logic             restart;
  logic             run;
  logic             tick;
  logic [WIDTH-1:0] count_inc;
  logic [WIDTH-1:0] count_dec;
  logic             up_term;
  logic             dn_term;

  assign mode      = mode_e'(mode_i);
  assign restart   = clear_i | load_i;
  // The prescaler is frozen once a one-shot has parked in DONE.
  assign run       = en_i & (state_q == ST_RUN);
  assign count_inc = count_q + 1'b1;
  assign count_dec = count_q - 1'b1;
  // Up terminal uses >= so a loaded value above max_i still terminates.
  assign up_term   = (count_q >= max_i);
  assign dn_term   = (count_q == '0);

  cfg_counter_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .restart_i (restart),
    .run_i     (run),
    .presc_i   (presc_i),
    .tick_o    (tick)
  );

  // Next count, pulses and FSM state; pulses default low so they last one cycle.
  always_comb begin
    count_d = count_q;
    state_d = state_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    if (clear_i) begin
      count_d = '0;
      state_d = ST_RUN;
    end else if (load_i) begin
      count_d = load_val_i;
      state_d = ST_RUN;
    end else if (tick) begin
      if (!dir_i) begin
        // Counting up toward max_i.
        if (mode == MODE_SAT) begin
          count_d = up_term ? max_i : count_inc;
        end else if (mode == MODE_ONESHOT) begin
          if (up_term) begin
            state_d = ST_DONE;
          end else begin
            count_d = count_inc;
            if (count_inc == max_i) begin
              state_d = ST_DONE;
            end
          end
        end else if (is_wrap_mode(mode)) begin
          if (up_term) begin
            count_d = '0;
            ovf_d   = 1'b1;
          end else begin
            count_d = count_inc;
          end
        end
      end else begin
        // Counting down toward zero; values above max_i decrement unclamped.
        if (mode == MODE_SAT) begin
          count_d = dn_term ? count_q : count_dec;
        end else if (mode == MODE_ONESHOT) begin
          if (dn_term) begin
            state_d = ST_DONE;
          end else begin
            count_d = count_dec;
            if (count_dec == '0) begin
              state_d = ST_DONE;
            end
          end
        end else if (is_wrap_mode(mode)) begin
          if (dn_term) begin
            count_d = max_i;
            unf_d   = 1'b1;
          end else begin
            count_d = count_dec;
          end
        end
      end
    end
  end

  // Count, pulse and state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      state_q <= ST_RUN;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      state_q <= state_d;
    end
  end

  assign count_o = count_q;
  assign ovf_o   = ovf_q;
  assign unf_o   = unf_q;
  assign done_o  = (state_q == ST_DONE);
  assign match_o = (count_q == cmp_i);

endmodule

// File: doc/cfg_counter.md
# cfg_counter

Parametrised, runtime-configurable counter: the next generation of the basic enable/clear/overflow counter. It adds up/down direction, a runtime terminal count, parallel load, a prescaler, wrap/saturate/one-shot modes and a compare-match output. It is the general-purpose tick/timer primitive for SoC peripherals such as timers, PWM bases and watchdog prescalers. It sits directly on the peripheral clock and is driven by register-file outputs.

## Interface
Parameters:
- WIDTH, 8, counter width in bits
- PRESCALE_W, 4, prescaler width in bits

Ports:
- clk_i  in  1  clock; all logic uses the rising edge
- rst_i  in  1  reset; synchronous, active-high
- en_i  in  1  count enable; gates the prescaler
- clear_i  in  1  synchronous clear
- load_i  in  1  parallel load strobe
- load_val_i  in  WIDTH  value applied on load
- dir_i  in  1  direction: 0 = up, 1 = down
- mode_i  in  2  00 WRAP, 01 SAT, 10 ONESHOT, 11 reserved (behaves as WRAP)
- max_i  in  WIDTH  terminal count; up terminal is max_i, down terminal is 0
- presc_i  in  PRESCALE_W  produce one tick every presc_i+1 enabled cycles
- cmp_i  in  WIDTH  compare value
- count_o  out  WIDTH  current count, registered
- ovf_o  out  1  one-cycle pulse on an up wrap, registered
- unf_o  out  1  one-cycle pulse on a down wrap, registered
- done_o  out  1  level; one-shot completed, registered
- match_o  out  1  combinational count_o == cmp_i

## Operation
- Priority per cycle: rst_i > clear_i > load_i > tick.
- Reset: count 0, prescaler 0, state RUN, ovf_o = unf_o = done_o = 0.
- Clear: count 0, prescaler 0, state RUN, done cleared.
- Load: count = load_val_i (not clamped), prescaler 0, state RUN, done cleared.
- Prescaler psc:
  - Advances only when en_i = 1 and state = RUN.
  - When psc == presc_i, a tick fires and psc goes to 0; otherwise psc increments.
  - With en_i = 0, psc holds.
  - presc_i = 0 ticks every enabled cycle, which is identical to the legacy counter.
  - If presc_i is lowered below psc, psc counts up and wraps modulo 2^PRESCALE_W. Software must clear or load after changing presc_i.
- Tick, up direction (terminal condition is count >= max_i):
  - WRAP: count goes to 0 and ovf_o pulses; otherwise count+1.
  - SAT: count is set to max_i with no pulse; otherwise count+1.
  - ONESHOT: at terminal, count holds and the state goes to DONE. Otherwise count+1, and if count+1 == max_i the state goes to DONE on the same edge.
- Tick, down direction (terminal condition is count == 0):
  - WRAP: count goes to max_i and unf_o pulses; otherwise count-1.
  - SAT: count holds at 0.
  - ONESHOT: at terminal, the state goes to DONE. Otherwise count-1, and if the result is 0 the state goes to DONE.
- Counting down from a value above max_i decrements normally; no clamp.
- FSM has two states, RUN and DONE.
  - DONE is reachable only in ONESHOT.
  - DONE exits only on clear, load or reset.
  - done_o = (state == DONE).
- Changing mode_i or dir_i takes effect on the next tick. State is not altered.
- Arithmetic is modulo 2^WIDTH. max_i = 2^WIDTH-1 in WRAP mode gives a natural roll-over.

## Timing
- Count latency: one edge after the tick cycle.
- With a fixed presc_i = P, N ticks require N·(P+1) enabled cycles after a clear, load or reset.
- ovf_o / unf_o are high exactly one cycle, coincident with the wrapped count_o value.
- done_o rises in the same cycle count_o first shows the terminal value.
- match_o follows count_o and cmp_i with no register stage.
- rst_i asserted mid-count with en_i high: all outputs reach reset values on the next edge, and no pulse is emitted.

## Structure
- cfg_counter_pkg holds:
  - mode_e: MODE_WRAP = 2'b00, MODE_SAT = 2'b01, MODE_ONESHOT = 2'b10, MODE_RSVD = 2'b11
  - state_e: ST_RUN, ST_DONE
- Sub-module cfg_counter_prescaler has parameter PRESCALE_W.
  - Inputs: clk_i, rst_i, restart (clear | load), run (en_i & RUN), presc_i.
  - Output: tick_o.
- The top level holds the count register, mode/direction logic and FSM.

## Test plan
All scenarios use WIDTH = 8.
- Legacy compatibility (up, WRAP, max_i = 10, presc_i = 0):
  - After reset with en_i low for 10 cycles, count stays 0.
  - 5 enabled cycles: count = 5.
  - 6 more enabled cycles: count = 0, with ovf_o high for exactly one cycle on the 0.
- Down SAT: load 3, dir_i = 1, 5 ticks: count 2, 1, 0, 0, 0; unf_o never asserts.
- Down WRAP (max_i = 9, count 0): 1 tick gives count = 9 with a single unf_o pulse.
- Prescaler (presc_i = 3): from clear, 12 enabled cycles give count = 3. Dropping en_i for 4 cycles mid-way delays the count by exactly 4 cycles.
- ONESHOT (up, max_i = 4): 6 ticks leave count = 4. done_o rises with count 4 and stays high. Loading 0 clears done_o, and counting resumes.
- Priority and match:
  - clear_i and load_i asserted on a tick cycle: count = 0.
  - rst_i mid-count: count, ovf_o, unf_o and done_o are 0 on the next edge.
  - cmp_i = 7: match_o is high exactly while count_o = 7.
